mmio_periph: RTL and testbench
==============================

# mmio_periph

Memory-mapped peripheral block for the single-cycle ARM core. It sits on the data bus beside the data RAM and consumes the processor's `MemWrite`, `DataAdr` and `WriteData`. It returns `ReadData` plus a select flag, so the data-memory mux can choose between RAM and I/O. It drives the board LEDs, provides synchronised and debounced switch inputs with a change flag, and has a 32-bit timer with compare/match.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hC000_0000: base of the I/O window. Decode is `DataAdr[31:8] == BASE_ADDR[31:8]`; offset is `DataAdr[7:0]`, word-aligned.
- `DEBOUNCE_CYCLES`, default 50000: stable-cycle count required before a switch change is accepted. Must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `MemWrite` in 1: write strobe from the core.
- `DataAdr` in 32: byte address from the core.
- `WriteData` in 32: store data from the core.
- `ReadData` out 32: combinational read data; 0 when not selected.
- `io_sel` out 1: combinational; 1 when `DataAdr` is in the I/O window.
- `switches` in 10: raw asynchronous board switches.
- `leds` out 10: registered LED drive.

## Operation
Register map (offset, access, meaning):
- 0x00 `LEDS`, RW, bits [9:0]. `leds` equals this register directly.
- 0x04 `SWITCHES`, RO, bits [9:0]: debounced switch vector.
- 0x08 `SW_STAT`, bit0 `chg`, W1C: sets when the debounced vector changes.
- 0x0C `TMR_CNT`, RW: timer count. A write loads the count.
- 0x10 `TMR_CMP`, RW: compare value.
- 0x14 `TMR_CTRL`, RW: bit0 `en`, bit1 `autoreload`; bit2 `match`, W1C.

Unmapped offsets read 0, and writes to them are ignored.

- **Write rule:** a write occurs on a rising edge when `MemWrite & io_sel`. Bits above each field's width are ignored on write and read as 0.
- **Reset values:** `leds` = 0, debounced vector = 0, `chg` = 0, `TMR_CNT` = 0, `TMR_CMP` = 32'hFFFF_FFFF, `TMR_CTRL` = 0. The synchroniser flops, candidate register and debounce counter also reset to 0. Reset asserted mid-debounce or mid-count discards all progress.
- **Switch path:**
  - 2-flop synchroniser, then a `candidate` register and a debounce counter `dcnt`.
  - If synced ≠ candidate: candidate ← synced, `dcnt` ← 0.
  - Else if candidate ≠ stable: `dcnt` increments. When `dcnt` == `DEBOUNCE_CYCLES`−1, stable ← candidate, `dcnt` ← 0, and `chg` sets.
  - Else `dcnt` holds at 0.
  - Any bounce restarts the count.
- **Timer (when `en`=1):**
  - If `TMR_CNT` == `TMR_CMP`: `match` sets. If `autoreload`=1, count ← 0; otherwise count increments.
  - If `TMR_CNT` ≠ `TMR_CMP`: count increments.
  - Increment wraps modulo 2^32 (32'hFFFF_FFFF → 0).
  - When `en`=0, the count holds.
- **Simultaneous events:**
  - A CPU write to `TMR_CNT` beats both increment and reload in the same cycle.
  - For W1C flags, a hardware set in the same cycle beats the clear, so the flag stays 1.
  - A write to `TMR_CTRL` with bit2=0 leaves `match` unchanged.

## Timing
- Reads are combinational, zero latency, and reflect register state before the current edge.
- Writes are visible on the first read after the write edge. `leds` changes on the write edge.
- Switch latency: a clean step sampled at edge k appears in `SWITCHES` after edge k+`DEBOUNCE_CYCLES`+2, i.e. `DEBOUNCE_CYCLES`+3 edges. `chg` sets on that same edge.
- Timer: `match` sets on the edge where the pre-edge count equals `TMR_CMP`.

## Configuration
- `MMIO_TIMER_EN` defined: the timer registers and logic at 0x0C–0x14 are present.
- Undefined: no timer flops are synthesised. Offsets 0x0C–0x14 read 0 and writes to them are ignored. The LED and switch behaviour is identical in both builds.

## Structure
- Package `mmio_pkg` holds:
  - offset constants: `OFS_LEDS`, `OFS_SWITCHES`, `OFS_SW_STAT`, `OFS_TMR_CNT`, `OFS_TMR_CMP`, `OFS_TMR_CTRL`;
  - `TMR_CTRL` bit indices;
  - the default `BASE_ADDR`.
- One sub-module, `sw_debounce`, parameterised by width and `DEBOUNCE_CYCLES`. It contains the synchroniser, candidate register and counter, and outputs `stable` and a one-cycle `changed` pulse.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `reset` 2 cycles. Reads give 0x00→0, 0x04→0, 0x10→32'hFFFF_FFFF, 0x14→0. `leds`=0.
- **LED write:** write 32'hFFFF_F2A5 to 0x00. `leds`=10'h2A5 after the edge; read 0x00→32'h2A5. Read of 0x40→0.
- **Switch step:** `switches` 0→10'h155 before edge k. 0x04 reads 0 through edge k+5 and 10'h155 after edge k+6. Read 0x08→1. Write 1 to 0x08, then read →0.
- **Switch bounce:** toggle bit0 every 2 cycles for 10 cycles, then hold. `SWITCHES` is unchanged until 7 edges after the last toggle.
- **Timer, autoreload:** `CMP`=3, `CTRL`=3. Count runs 0,1,2,3,0,1…; `match` sets after the first edge from count 3. A W1C write on a match edge leaves `match`=1.
- **Timer, no autoreload:** load `CNT`=32'hFFFF_FFFE with `en`=1. Count wraps to 0 after 2 edges. A `CNT` write during an enabled increment wins.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped I/O block: register offsets,
// timer control bit positions, field widths and the default I/O window base.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hC000_0000;

  localparam int unsigned LED_W = 10;
  localparam int unsigned SW_W  = 10;

  localparam logic [7:0] OFS_LEDS     = 8'h00;
  localparam logic [7:0] OFS_SWITCHES = 8'h04;
  localparam logic [7:0] OFS_SW_STAT  = 8'h08;
  localparam logic [7:0] OFS_TMR_CNT  = 8'h0C;
  localparam logic [7:0] OFS_TMR_CMP  = 8'h10;
  localparam logic [7:0] OFS_TMR_CTRL = 8'h14;

  localparam int unsigned TMR_CTRL_EN    = 0;
  localparam int unsigned TMR_CTRL_AR    = 1;
  localparam int unsigned TMR_CTRL_MATCH = 2;

  localparam logic [31:0] TMR_CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a candidate/stable debouncer; changed_o
// is high during the cycle whose closing edge updates stable_o.
module sw_debounce #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             changed_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    dcnt_q, dcnt_d;
  logic             changed_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      dcnt_q   <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Any difference between the synced input and the candidate restarts the count.
  always_comb begin
    cand_d    = cand_q;
    stable_d  = stable_q;
    dcnt_d    = dcnt_q;
    changed_s = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      dcnt_d = '0;
    end else if (cand_q != stable_q) begin
      if (dcnt_q == LAST) begin
        stable_d  = cand_q;
        dcnt_d    = '0;
        changed_s = 1'b1;
      end else begin
        dcnt_d = dcnt_q + CW'(1);
      end
    end else begin
      dcnt_d = '0;
    end
  end

  assign stable_o  = stable_q;
  assign changed_o = changed_s;

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped LED / debounced switch / timer peripheral for the ARM data bus.
// Define MMIO_TIMER_EN to build the timer registers at offsets 0x0C-0x14.
module mmio_periph
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic [31:0]     DataAdr,
  input  logic [31:0]     WriteData,
  output logic [31:0]     ReadData,
  output logic            io_sel,
  input  logic [SW_W-1:0] switches,
  output logic [LED_W-1:0] leds
);

  logic [7:0]       ofs_s;
  logic             we_s;
  logic [31:0]      rdata_s;
  logic [LED_W-1:0] leds_q, leds_d;
  logic             chg_q, chg_d;
  logic [SW_W-1:0]  sw_stable_s;
  logic             sw_changed_s;

  assign io_sel = (DataAdr[31:8] == BASE_ADDR[31:8]);
  assign ofs_s  = DataAdr[7:0];
  assign we_s   = MemWrite & io_sel;

  sw_debounce #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (switches),
    .stable_o  (sw_stable_s),
    .changed_o (sw_changed_s)
  );

  // LED register and the switch-change flag; a hardware set outranks a W1C.
  always_comb begin
    leds_d = leds_q;
    chg_d  = chg_q;
    if (we_s && (ofs_s == OFS_LEDS)) begin
      leds_d = WriteData[LED_W-1:0];
    end else begin
      leds_d = leds_q;
    end
    if (sw_changed_s) begin
      chg_d = 1'b1;
    end else if (we_s && (ofs_s == OFS_SW_STAT) && WriteData[0]) begin
      chg_d = 1'b0;
    end else begin
      chg_d = chg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      chg_q  <= chg_d;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        match_q, match_d;
  logic        hit_s;

  assign hit_s = en_q && (cnt_q == cmp_q);

  // Timer next state: a CPU load of the count beats increment and reload.
  always_comb begin
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    ar_d    = ar_q;
    match_d = match_q;
    if (we_s && (ofs_s == OFS_TMR_CNT)) begin
      cnt_d = WriteData;
    end else if (hit_s && ar_q) begin
      cnt_d = 32'd0;
    end else if (en_q) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (we_s && (ofs_s == OFS_TMR_CMP)) begin
      cmp_d = WriteData;
    end else begin
      cmp_d = cmp_q;
    end
    if (we_s && (ofs_s == OFS_TMR_CTRL)) begin
      en_d = WriteData[TMR_CTRL_EN];
      ar_d = WriteData[TMR_CTRL_AR];
    end else begin
      en_d = en_q;
      ar_d = ar_q;
    end
    if (hit_s) begin
      match_d = 1'b1;
    end else if (we_s && (ofs_s == OFS_TMR_CTRL) && WriteData[TMR_CTRL_MATCH]) begin
      match_d = 1'b0;
    end else begin
      match_d = match_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 32'd0;
      cmp_q   <= TMR_CMP_RESET;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      ar_q    <= ar_d;
      match_q <= match_d;
    end
  end
`else
  logic unused_wdata_s;
  assign unused_wdata_s = &{1'b0, WriteData[31:LED_W]};
`endif

  // Read mux reflects register state ahead of the current edge.
  always_comb begin
    rdata_s = 32'd0;
    case (ofs_s)
      OFS_LEDS:     rdata_s = {{(32-LED_W){1'b0}}, leds_q};
      OFS_SWITCHES: rdata_s = {{(32-SW_W){1'b0}}, sw_stable_s};
      OFS_SW_STAT:  rdata_s = {31'd0, chg_q};
`ifdef MMIO_TIMER_EN
      OFS_TMR_CNT:  rdata_s = cnt_q;
      OFS_TMR_CMP:  rdata_s = cmp_q;
      OFS_TMR_CTRL: rdata_s = {29'd0, match_q, ar_q, en_q};
`endif
      default:      rdata_s = 32'd0;
    endcase
  end

  assign ReadData = io_sel ? rdata_s : 32'd0;
  assign leds     = leds_q;

endmodule

// File: tb/tb_mmio_periph.sv
// Scoreboard bench for mmio_periph with DEBOUNCE_CYCLES=4; timer checks are
// compiled in only when MMIO_TIMER_EN is defined, otherwise the timer window must read 0.
module tb_mmio_periph;

  localparam logic [31:0] B = 32'hC000_0000;
  localparam int K_RD  = 0;
  localparam int K_LED = 1;
  localparam int K_SEL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        io_sel;
  logic [9:0]  switches;
  logic [9:0]  leds;

  typedef struct {
    logic [31:0] val;
    logic [31:0] adr;
    int          kind;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_x;
  logic [31:0] mon_act;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          id_cnt = 0;

  always #5 clk = ~clk;

  mmio_periph #(
    .BASE_ADDR       (32'hC000_0000),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .io_sel    (io_sel),
    .switches  (switches),
    .leds      (leds)
  );

  // Monitor: pops one expectation per presented sample, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expectation t=%0t", $time);
      end else begin
        mon_x = exp_q.pop_front();
        case (mon_x.kind)
          K_RD:    mon_act = ReadData;
          K_LED:   mon_act = {22'd0, leds};
          default: mon_act = {31'd0, io_sel};
        endcase
        if (mon_act !== mon_x.val) begin
          errors++;
          $display("FAIL chk%0d kind=%0d adr=%h got %h expected %h", mon_x.id, mon_x.kind,
                   mon_x.adr, mon_act, mon_x.val);
        end
      end
    end
  end

  task automatic idle();
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input int kind);
    exp_t x;
    MemWrite = 1'b0;
    DataAdr  = a;
    x.val    = e;
    x.adr    = a;
    x.kind   = kind;
    x.id     = id_cnt;
    id_cnt++;
    exp_q.push_back(x);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
    switches  = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    rd(B + 32'h00, 32'd0, K_RD);
    rd(B + 32'h04, 32'd0, K_RD);
    rd(B + 32'h08, 32'd0, K_RD);
    rd(B + 32'h00, 32'd0, K_LED);
`ifdef MMIO_TIMER_EN
    rd(B + 32'h0C, 32'd0, K_RD);
    rd(B + 32'h10, 32'hFFFF_FFFF, K_RD);
    rd(B + 32'h14, 32'd0, K_RD);
`else
    rd(B + 32'h0C, 32'd0, K_RD);
    rd(B + 32'h10, 32'd0, K_RD);
    rd(B + 32'h14, 32'd0, K_RD);
`endif

    // address decode
    rd(B + 32'h40, 32'd1, K_SEL);
    rd(B + 32'h40, 32'd0, K_RD);
    rd(32'h0000_0000, 32'd0, K_SEL);
    rd(32'hC000_0100, 32'd0, K_SEL);

    // LED write, upper bits dropped; writes outside the window ignored
    wr(B + 32'h00, 32'hFFFF_F2A5);
    rd(B + 32'h00, 32'h2A5, K_LED);
    rd(B + 32'h00, 32'h2A5, K_RD);
    wr(32'h0000_0000, 32'h3FF);
    rd(B + 32'h00, 32'h2A5, K_LED);
    wr(B + 32'h04, 32'h3FF);
    rd(B + 32'h04, 32'd0, K_RD);

    // clean switch step: first read samples the state before edge k
    switches = 10'h155;
    for (int i = 0; i < 7; i++) rd(B + 32'h04, 32'd0, K_RD);
    rd(B + 32'h04, 32'h155, K_RD);
    rd(B + 32'h08, 32'd1, K_RD);
    wr(B + 32'h08, 32'd1);
    rd(B + 32'h08, 32'd0, K_RD);

    // bounce on bit0, ending on 0x154
    for (int t = 0; t < 5; t++) begin
      switches[0] = ~switches[0];
      rd(B + 32'h04, 32'h155, K_RD);
      rd(B + 32'h04, 32'h155, K_RD);
    end
    for (int i = 0; i < 5; i++) rd(B + 32'h04, 32'h155, K_RD);
    rd(B + 32'h04, 32'h154, K_RD);
    rd(B + 32'h08, 32'd1, K_RD);
    wr(B + 32'h08, 32'd1);

`ifdef MMIO_TIMER_EN
    // autoreload at CMP=3
    wr(B + 32'h10, 32'd3);
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h14, 32'd3);
    rd(B + 32'h0C, 32'd0, K_RD);
    rd(B + 32'h0C, 32'd1, K_RD);
    rd(B + 32'h0C, 32'd2, K_RD);
    rd(B + 32'h14, 32'd3, K_RD);
    rd(B + 32'h14, 32'd7, K_RD);
    wr(B + 32'h14, 32'd7);
    rd(B + 32'h14, 32'd3, K_RD);
    wr(B + 32'h14, 32'd7);
    rd(B + 32'h14, 32'd7, K_RD);
    rd(B + 32'h0C, 32'd1, K_RD);
    wr(B + 32'h14, 32'd0);
    rd(B + 32'h14, 32'd4, K_RD);
    rd(B + 32'h0C, 32'd3, K_RD);
    rd(B + 32'h0C, 32'd3, K_RD);

    // free-running wrap and a load that beats the increment
    wr(B + 32'h14, 32'd5);
    wr(B + 32'h0C, 32'hFFFF_FFFE);
    rd(B + 32'h0C, 32'hFFFF_FFFE, K_RD);
    rd(B + 32'h0C, 32'hFFFF_FFFF, K_RD);
    rd(B + 32'h0C, 32'd0, K_RD);
    wr(B + 32'h0C, 32'h100);
    rd(B + 32'h0C, 32'h100, K_RD);
    rd(B + 32'h0C, 32'h101, K_RD);
    rd(B + 32'h14, 32'd5, K_RD);
`else
    wr(B + 32'h0C, 32'd5);
    rd(B + 32'h0C, 32'd0, K_RD);
    wr(B + 32'h14, 32'd1);
    rd(B + 32'h14, 32'd0, K_RD);
`endif

    // reset mid-operation discards state
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    rd(B + 32'h00, 32'd0, K_LED);
    rd(B + 32'h04, 32'd0, K_RD);
    rd(B + 32'h08, 32'd0, K_RD);
`ifdef MMIO_TIMER_EN
    rd(B + 32'h10, 32'hFFFF_FFFF, K_RD);
    rd(B + 32'h0C, 32'd0, K_RD);
`endif

    idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
